fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch buffer between the program-counter/instruction-memory fetch stage and the decode stage of the MIPS32 pipeline. Each entry holds a fetched `{pc, instr}` pair, and the buffer hands pairs to decode over a valid/ready handshake. It absorbs decode stalls without freezing the PC, and a branch/jump redirect drops every buffered instruction in one cycle.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, at least 2
- `XLEN`, 32, width of PC and instruction

Ports:
- `clk` in 1 — single clock; all state updates on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — fetch stage presents a pair
- `in_ready` out 1 — buffer accepts the pair this cycle
- `in_pc` in XLEN — PC of the fetched instruction
- `in_instr` in XLEN — fetched instruction word
- `out_valid` out 1 — pair available to decode
- `out_ready` in 1 — decode consumes the pair this cycle
- `out_pc` out XLEN — PC of the head entry
- `out_pc_plus4` out XLEN — `out_pc + 4`, modulo 2^32
- `out_instr` out XLEN — instruction of the head entry
- `flush` in 1 — redirect; discards all contents
- `count` out $clog2(DEPTH)+1 — number of stored entries

## Operation
- Circular FIFO. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. Full when the index bits are equal and the wrap bits differ. Empty when the pointers are equal.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = !full && rst_n`. There is no lookahead: when full, `in_ready` is 0 even if a pop happens in the same cycle.
- `out_valid = !empty && !flush`.
- `out_pc`, `out_instr` and `out_pc_plus4` show the head entry when `out_valid` = 1. Otherwise `out_pc` = 0, `out_instr` = 32'h0000_0000 (NOP) and `out_pc_plus4` = 4.
- Simultaneous push and pop when neither full nor empty: both happen and `count` is unchanged.
- `flush` has the highest priority. On the next edge both pointers return to 0 and `count` to 0. Any push or pop in the flush cycle is discarded and has no effect.
- `out_pc_plus4` wraps: 32'hFFFF_FFFC gives 32'h0000_0000.
- The block contains no FSM. Its state is the two pointers and the storage array.

## Timing
- Reset values: pointers 0, `count` 0, `in_ready` 0 while `rst_n` = 0, `out_valid` 0, `out_pc` 0, `out_instr` 0, `out_pc_plus4` 4.
- `in_ready` rises combinationally once `rst_n` deasserts.
- Reset asserted mid-operation: contents are lost immediately and asynchronously.
- Latency without bypass: a pair pushed at edge N is visible on `out_*` in cycle N+1.
- Sustained throughput is 1 pair/cycle when `DEPTH` ≥ 2 and decode is always ready.
- `count` is registered and reflects the state after the last edge.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined: when the buffer is empty, `in_valid` = 1 and `flush` = 0, the input pair drives `out_*` combinationally and `out_valid = in_valid`.
  - If `out_ready` = 1 as well, the pair is consumed without being stored; no push occurs and `count` stays 0.
  - If `out_ready` = 0, the pair is pushed normally.
- `FETCH_BUFFER_BYPASS_EN` undefined: `out_valid` comes only from stored entries, so the minimum latency is one cycle.

## Structure
- Shared package `mips_pkg`:
  - `XLEN` = 32
  - `NOP_INSTR` = 32'h0000_0000
  - `PC_STEP` = 4
  - `typedef struct packed { logic [XLEN-1:0] pc; logic [XLEN-1:0] instr; } fetch_entry_t`
- One sub-module, `fetch_buffer_ram`: a `DEPTH` x `fetch_entry_t` register array with synchronous write and asynchronous read. It has no reset; validity is tracked by the pointers.
- Pointer, flag and bypass logic stay in `fetch_buffer`.

## Test plan
- Reset release, then push PC 0x0, 0x4, 0x8, 0xC with `out_ready` = 0 → `count` = 4 and `in_ready` = 0; a fifth pair offered at PC 0x10 is not accepted.
- From full, `out_ready` = 1 for four cycles → `out_pc` reads 0x0, 0x4, 0x8, 0xC in order, `out_pc_plus4` = `out_pc` + 4, then `out_valid` = 0 and `out_instr` = 0.
- Continuous push and pop with `in_pc` stepping by 4 for 20 cycles → `count` is constant; the pointers wrap and order is preserved.
- Three entries held plus `flush` = 1 together with `in_valid` = 1 (PC 0x40) → `out_valid` = 0 in the flush cycle; next cycle `count` = 0 and PC 0x40 is absent.
- Push `in_pc` = 32'hFFFF_FFFC → `out_pc_plus4` = 0.
- `FETCH_BUFFER_BYPASS_EN` defined, buffer empty, `in_valid` = `out_ready` = 1 with PC 0x100 → `out_valid` = 1 with `out_pc` = 0x100 in the same cycle, and `count` stays 0.
- `FETCH_BUFFER_BYPASS_EN` undefined, same stimulus → `out_pc` = 0x100 appears one cycle later.
- `rst_n` asserted with 2 entries held → `count`, `out_valid` and `in_ready` drop to 0 without a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline types and constants used by the fetch/decode boundary.
// Latency: n/a (types only).
// Backpressure: n/a.
package mips_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer_ram.sv
// Fetch buffer storage: DEPTH x fetch_entry_t, synchronous write, asynchronous read, no reset.
// Latency: a write at edge N is readable combinationally in cycle N+1.
// Backpressure: none; the owner's pointers decide when writes are legal.
module fetch_buffer_ram
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  fetch_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fetch_entry_t rdata_o
);
    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer ({pc, instr} FIFO) between fetch and decode; flush drops all entries.
// Latency: 1 cycle push-to-out; 0 cycles when empty with FETCH_BUFFER_BYPASS_EN defined.
// Backpressure: in_ready low when full (no same-cycle pop lookahead); holds head while out_ready low.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = mips_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_pc_plus4,
    output logic [XLEN-1:0]          out_instr,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   empty, full, push, pop, bypass;
    mips_pkg::fetch_entry_t wr_entry, head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready = !full && rst_n;
    assign count    = wr_ptr_q - rd_ptr_q;
    assign wr_entry = '{pc: in_pc, instr: in_instr};

    fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head)
    );

    always_comb begin
        bypass = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass = empty && in_valid && !flush;
`endif
        out_valid = bypass || (!empty && !flush);
        if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (out_valid) begin
            out_pc    = head.pc;
            out_instr = head.instr;
        end else begin
            out_pc    = '0;
            out_instr = mips_pkg::NOP_INSTR;
        end
        out_pc_plus4 = out_pc + mips_pkg::PC_STEP;

        // A bypassed pair that decode takes this cycle never touches storage.
        push = in_valid && in_ready && !flush && !(bypass && out_ready);
        pop  = !empty && !flush && out_ready;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed table, corner sequences, random traffic vs a queue model.
module tb_fetch_buffer;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_pc_plus4, out_instr;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t q[$];

    typedef struct {
        logic        iv; logic [31:0] pc; logic ordy; logic fl;
        logic        e_ir; logic e_ov; logic [31:0] e_pc; int e_cnt;
    } vec_t;
    vec_t tbl [10];

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid = iv; in_pc = pc; in_instr = instr_of(pc); out_ready = ordy; flush = fl;
    endtask

    // One cycle against the queue model: check outputs before the edge, then advance the model.
    task automatic cyc(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        logic byp, e_ov, acc;
        logic [31:0] e_pc, e_in;
        int n;
        entry_t e;
        drive(iv, pc, ordy, fl);
        #1;
        n    = q.size();
        byp  = BYP && n == 0 && iv && !fl;
        e_ov = byp || (n != 0 && !fl);
        if (byp) begin
            e_pc = pc; e_in = instr_of(pc);
        end else if (e_ov) begin
            e_pc = q[0].pc; e_in = q[0].instr;
        end else begin
            e_pc = 32'h0; e_in = 32'h0;
        end
        chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("out_pc", out_pc, e_pc);
        chk("out_instr", out_instr, e_in);
        chk("out_pc_plus4", out_pc_plus4, e_pc + 32'd4);
        chk("count", 32'(count), 32'(n));
        acc = iv && n < DEPTH && !(byp && ordy);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && n != 0) void'(q.pop_front());
            if (acc) begin
                e.pc = pc; e.instr = instr_of(pc);
                q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        // Fill to full, offer a fifth pair, then drain in order.
        tbl[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b1, BYP,  32'h0, 0};
        tbl[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1};
        tbl[2] = '{1'b1, 32'h8,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2};
        tbl[3] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 3};
        tbl[4] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4};
        tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4};
        tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 3};
        tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 2};
        tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 1};
        tbl[9] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0};

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_pc_plus4", out_pc_plus4, 32'h4);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_pc_plus4", i), out_pc_plus4, tbl[i].e_pc + 32'd4);
            chk($sformatf("tbl%0d_out_instr", i), out_instr,
                tbl[i].e_ov ? instr_of(tbl[i].e_pc) : 32'h0);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            @(posedge clk); #1;
        end

        // Continuous push/pop with one entry held: count stays put, pointers wrap.
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with three held and a concurrent push of 0x40.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        q.delete();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_out_valid_after", 32'(out_valid), 32'h0);
        chk("flush_out_pc_after", out_pc, 32'h0);
        @(posedge clk); #1;

        // PC + 4 wraps at the top of the address space.
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", out_pc_plus4, 32'h0);
        @(posedge clk); #1;

        // Empty buffer, pair offered with decode ready.
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        #1;
        chk("byp_out_valid", 32'(out_valid), 32'(BYP));
        chk("byp_out_pc", out_pc, BYP ? 32'h100 : 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("byp_next_count", 32'(count), BYP ? 32'h0 : 32'h1);
        chk("byp_next_out_pc", out_pc, BYP ? 32'h0 : 32'h100);
        @(posedge clk); #1;

        // Asynchronous reset with two entries held.
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_arst_count", 32'(count), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        // Random traffic against the queue model.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(3) != 0), {$urandom_range(32'h3FFF_FFFF), 2'b00},
                $urandom_range(1) == 1, ($urandom_range(15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
